// File: rtl/dpmem_rr_arbiter.sv
// rtl/dpmem_rr_arbiter.sv - two-port round-robin sequencer for a fixed-latency memory bank
module dpmem_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int WR_LATENCY = 4,
    parameter int RD_LATENCY = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  wr_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  wr_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  done_a,
    output logic                  done_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // The wait counter holds LAT-1 down to 0, so LAT up to 15 fits in four bits.
    localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       owner_b;   // 1 when B owns the current transaction
    logic       last_b;    // 1 when the most recent grant went to B
    logic       grant;
    logic       win_b;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grant decision and round-robin winner (on a tie the port not granted last wins).
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        win_b      = req_b && (!req_a || !last_b);
        case (state)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    state_next = ST_ISSUE;
                    grant      = 1'b1;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered outputs: capture at grant, strobe the bank, time the access, report completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
            cnt       <= 4'd0;
            owner_b   <= 1'b0;
            last_b    <= 1'b1;
        end else begin
            mem_en <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner_b   <= win_b;
                        last_b    <= win_b;
                        gnt_a     <= !win_b;
                        gnt_b     <= win_b;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_wr    <= win_b ? wr_b : wr_a;
                        mem_addr  <= win_b ? addr_b : addr_a;
                        mem_wdata <= win_b ? wdata_b : wdata_a;
                    end
                end
                ST_ISSUE: begin
                    cnt <= mem_wr ? WR_LOAD : RD_LOAD;
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        done_a <= !owner_b;
                        done_b <= owner_b;
                        if (!mem_wr) begin
                            if (owner_b) begin
                                rdata_b <= mem_rdata;
                            end else begin
                                rdata_a <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    gnt_a <= 1'b0;
                    gnt_b <= 1'b0;
                    busy  <= 1'b0;
                    if (mem_wr) begin
                        if (wr_count != '1) begin
                            wr_count <= wr_count + 1'b1;
                        end
                    end else begin
                        if (rd_count != '1) begin
                            rd_count <= rd_count + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
